// File: rtl/ds_pkg.sv
// Shared defaults and derived widths for the 2x2 box-filter decimator.
package ds_pkg;

    localparam int DEF_IMG_W = 200;
    localparam int DEF_IMG_H = 200;
    localparam int DEF_DW    = 8;

    localparam int COL_W     = $clog2(DEF_IMG_W);
    localparam int ROW_W     = $clog2(DEF_IMG_H);
    localparam int BUF_DEPTH = DEF_IMG_W / 2;
    localparam int SUM_W     = DEF_DW + 2;

    typedef logic [DEF_DW-1:0] pix_t;

endpackage

// File: rtl/ds_if.sv
// Pixel stream bundle: input stream, output stream and frame marker.
interface ds_if
    import ds_pkg::*;
#(
    parameter int DW = DEF_DW
);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          frame_done;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, frame_done
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, frame_done
    );

endinterface

// File: rtl/ds_line_buf.sv
// Half-width line buffer holding horizontal pair sums of the even row.
module ds_line_buf
    import ds_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    parameter int WIDTH = DEF_DW + 1,
    parameter int AW    = $clog2(BUF_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // No reset: every entry is written on an even row before use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/downsample_2x2.sv
// Streaming 2x2 box-filter decimator with single-entry output register.
module downsample_2x2
    import ds_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int DW    = DEF_DW
) (
    input  logic clk,
    input  logic rst_n,
    ds_if.slave  bus
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int DEPTH = IMG_W / 2;
    localparam int KW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW    = DW + 2;

    generate
        if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0) begin : g_bad_dims
            $error("downsample_2x2: IMG_W and IMG_H must be even");
        end
    endgenerate

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] pair_q, pair_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;

    logic          accept;
    logic          col_last;
    logic          row_last;
    logic [DW:0]   pair_sum;
    logic [DW:0]   buf_rd;
    logic [SW-1:0] total;
    logic [SW-1:0] rounded;
    logic [KW-1:0] k;
    logic          buf_we;

    assign bus.in_ready = ~out_valid_q | bus.out_ready;

    assign accept   = bus.in_valid & bus.in_ready;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign pair_sum = {1'b0, pair_q} + {1'b0, bus.in_data};
    assign k        = KW'(col_q >> 1);
    assign buf_we   = accept & col_q[0] & ~row_q[0];
    assign total    = {1'b0, buf_rd} + {1'b0, pair_sum};
    assign rounded  = total + SW'(2);

    ds_line_buf #(
        .DEPTH (DEPTH),
        .WIDTH (DW + 1),
        .AW    (KW)
    ) u_line_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (k),
        .wdata (pair_sum),
        .raddr (k),
        .rdata (buf_rd)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q & ~bus.out_ready;
        frame_done_d = 1'b0;
        if (accept) begin
            // Odd row, odd col completes a block and overwrites any
            // output consumed on this same edge.
            unique case (1'b1)
                ~col_q[0]: begin
                    pair_d = bus.in_data;
                end
                col_q[0] & row_q[0]: begin
                    out_valid_d  = 1'b1;
                    out_data_d   = DW'(rounded >> 2);
                    frame_done_d = col_last & row_last;
                end
                default: begin
                end
            endcase
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_q       <= pair_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_downsample_2x2.sv
// Randomized bench for downsample_2x2 against a 2x2 rounded-average model.
module tb_downsample_2x2;
    import ds_pkg::*;

    localparam int W    = 24;
    localparam int H    = 16;
    localparam int NPIX = W * H;
    localparam int NOUT = NPIX / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ds_if #(.DW(8)) bus ();

    downsample_2x2 #(
        .IMG_W (W),
        .IMG_H (H),
        .DW    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    pix_t img [NPIX];
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int fd_q [$];
    logic stall_q = 1'b0;
    logic [7:0] held_q = '0;
    int gap_pct = 0;
    int rdy_pct = 100;

    // Observes the bus mid-cycle; values here decide the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            n_cmp++;
            if (bus.in_ready !== (~bus.out_valid | bus.out_ready)) begin
                n_err++;
                $display("FAIL in_ready got %b valid %b ready %b",
                         bus.in_ready, bus.out_valid, bus.out_ready);
            end
            if (stall_q) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== held_q) begin
                    n_err++;
                    $display("FAIL stall_hold got %b/%h exp 1/%h",
                             bus.out_valid, bus.out_data, held_q);
                end
            end
            if (bus.frame_done === 1'b1) begin
                fd_q.push_back(got_q.size());
                n_cmp++;
                if (bus.out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL fd_valid got %b exp 1", bus.out_valid);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
                got_q.push_back(bus.out_data);
            stall_q = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            held_q  = bus.out_data;
        end
    end

    function automatic void model();
        for (int by = 0; by < H / 2; by++) begin
            for (int bx = 0; bx < W / 2; bx++) begin
                int s;
                int t;
                t = (2 * by) * W + 2 * bx;
                s = int'(img[t]) + int'(img[t + 1])
                  + int'(img[t + W]) + int'(img[t + W + 1]);
                exp_q.push_back(8'((s + 2) / 4));
            end
        end
    endfunction

    task automatic clear();
        got_q.delete();
        exp_q.delete();
        fd_q.delete();
    endtask

    task automatic rand_img();
        for (int i = 0; i < NPIX; i++) img[i] = pix_t'($urandom_range(255));
    endtask

    task automatic drive_pixel(input logic [7:0] p);
        int budget;
        bit done;
        budget = 0;
        done = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            bus.in_valid  = ($urandom_range(99) >= gap_pct);
            bus.in_data   = p;
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                done = 1;
            end else if (++budget > 1000) begin
                n_cmp++;
                n_err++;
                $display("FAIL input_timeout got stalled exp accept");
                done = 1;
            end
        end
    endtask

    task automatic send(input int first, input int count);
        for (int i = first; i < first + count; i++) drive_pixel(img[i]);
    endtask

    task automatic drain();
        bit idle;
        idle = 0;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (!bus.out_valid) idle = 1;
        end
        n_cmp++;
        if (!idle) begin
            n_err++;
            $display("FAIL drain got out_valid 1 exp 0");
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp += 4;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_in_ready got %b exp 1", bus.in_ready);
        end
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_out_valid got %b exp 0", bus.out_valid);
        end
        if (bus.out_data !== 8'h00) begin
            n_err++;
            $display("FAIL rst_out_data got %h exp 00", bus.out_data);
        end
        if (bus.frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_frame_done got %b exp 0", bus.frame_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_patterns();
        logic [7:0] want [4];
        want[0] = 8'h03;
        want[1] = 8'h00;
        want[2] = 8'h01;
        want[3] = 8'hFF;
        for (int i = 0; i < NPIX; i++) img[i] = '0;
        img[0] = 8'd1;  img[1] = 8'd2;  img[W] = 8'd3;  img[W + 1] = 8'd4;
        img[W + 3] = 8'd1;
        img[5] = 8'd1;  img[W + 5] = 8'd1;
        img[6] = 8'hFF; img[7] = 8'hFF;
        img[W + 6] = 8'hFF; img[W + 7] = 8'hFE;
        clear();
        model();
        gap_pct = 0;
        rdy_pct = 100;
        send(0, NPIX);
        drain();
        n_cmp++;
        if (got_q.size() != NOUT) begin
            n_err++;
            $display("FAIL pat_count got %0d exp %0d", got_q.size(), NOUT);
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== want[i]) begin
                n_err++;
                $display("FAIL pat_block%0d got %h exp %h", i, got_q[i], want[i]);
            end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL pat_out%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_constant();
        for (int i = 0; i < NPIX; i++) img[i] = 8'hFF;
        clear();
        gap_pct = 0;
        rdy_pct = 100;
        send(0, NPIX);
        drain();
        n_cmp += 2;
        if (got_q.size() != NOUT) begin
            n_err++;
            $display("FAIL const_count got %0d exp %0d", got_q.size(), NOUT);
        end
        if (fd_q.size() != 1 || fd_q[0] != NOUT - 1) begin
            n_err++;
            $display("FAIL const_fd got %0d pulses first %0d exp 1 at %0d",
                     fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : -1, NOUT - 1);
        end
        foreach (got_q[i]) begin
            n_cmp++;
            if (got_q[i] !== 8'hFF) begin
                n_err++;
                $display("FAIL const_out%0d got %h exp ff", i, got_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        rand_img();
        clear();
        model();
        gap_pct = 0;
        rdy_pct = 50;
        send(0, NPIX);
        drain();
        n_cmp += 2;
        if (got_q.size() != NOUT) begin
            n_err++;
            $display("FAIL bp_count got %0d exp %0d", got_q.size(), NOUT);
        end
        if (fd_q.size() != 1 || fd_q[0] != NOUT - 1) begin
            n_err++;
            $display("FAIL bp_fd got %0d pulses exp 1", fd_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL bp_out%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        rand_img();
        gap_pct = 20;
        rdy_pct = 70;
        send(0, 9 * W + 5);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp += 2;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_valid got %b exp 0", bus.out_valid);
        end
        if (bus.frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_fd got %b exp 0", bus.frame_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rand_img();
        clear();
        model();
        send(0, NPIX);
        drain();
        n_cmp += 2;
        if (got_q.size() != NOUT) begin
            n_err++;
            $display("FAIL midrst_count got %0d exp %0d", got_q.size(), NOUT);
        end
        if (fd_q.size() != 1 || fd_q[0] != NOUT - 1) begin
            n_err++;
            $display("FAIL midrst_fd_pulse got %0d pulses exp 1", fd_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL midrst_out%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear();
        gap_pct = 30;
        rdy_pct = 70;
        rand_img();
        model();
        send(0, NPIX);
        rand_img();
        model();
        send(0, NPIX);
        drain();
        n_cmp += 2;
        if (got_q.size() != 2 * NOUT) begin
            n_err++;
            $display("FAIL b2b_count got %0d exp %0d", got_q.size(), 2 * NOUT);
        end
        if (fd_q.size() != 2 || fd_q[0] != NOUT - 1 || fd_q[1] != 2 * NOUT - 1) begin
            n_err++;
            $display("FAIL b2b_fd got %0d pulses exp 2 at %0d,%0d",
                     fd_q.size(), NOUT - 1, 2 * NOUT - 1);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL b2b_out%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_patterns();
        test_constant();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
